fifo_wr_arb: RTL and testbench

Single-clock write-port arbiter and pointer controller for the team's FIFO. It shares one FIFO write port between NREQ requesters using round-robin arbitration, with an optional per-requester lock for bursts. It owns the write and read pointers, drives the storage array's write and read addresses, and produces the full, empty and occupancy status that the rest of the FIFO logic consumes.

---
 rtl/fifo_wr_arb_pkg.sv | 16 +
 rtl/fifo_wr_arb_rr_pick.sv | 31 +++
 rtl/fifo_wr_arb.sv | 132 +++++++++++++
 tb/tb_fifo_wr_arb.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arb_pkg.sv
// fifo_wr_arb_pkg
// Shared types and helpers for the FIFO write-port arbiter.
//   arb_state_e : arbiter state encoding (free arbitration / locked burst)
//   rr_next     : round-robin successor of an index within 0..n-1
package fifo_wr_arb_pkg;

   typedef enum logic {
      StArb,
      StLocked
   } arb_state_e;

   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// rr_pick
// Combinational round-robin picker: grants the first set bit of req, searching
// from index prio upward and wrapping modulo N.
//   req  : request vector
//   prio : index searched first
//   gnt  : one-hot grant, or all zero when req is zero
module rr_pick #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]                          req,
   input  logic [((N > 1) ? $clog2(N) : 1)-1:0]  prio,
   output logic [N-1:0]                          gnt
);

   logic found;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      // Outer loop walks the search order; inner loop keeps every index constant.
      for (int unsigned k = 0; k < N; k++) begin
         for (int unsigned i = 0; i < N; i++) begin
            if (!found && req[i] && (i == (32'(prio) + k) % N)) begin
               gnt[i] = 1'b1;
               found  = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb
// Shares one FIFO write port among NREQ requesters (round-robin with optional
// burst lock) and owns the FIFO read/write pointers and status.
//   clk, rst            : clock, asynchronous active-high reset
//   req, lock, wdata    : requester side; transfer(i) = req[i] & gnt[i]
//   gnt                 : one-hot grant (zero while full or in reset)
//   rd_en, rd_ack       : pop request / pop accepted
//   mem_we/waddr/wdata  : storage write port
//   mem_raddr           : storage read address
//   wr_ptr_bin, rd_ptr_bin, fifo_full, fifo_empty, fifo_count : pointers and status
module fifo_wr_arb
   import fifo_wr_arb_pkg::*;
#(
   parameter int unsigned SIZE  = 4,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned NREQ  = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ-1:0]         lock,
   input  logic [NREQ*WIDTH-1:0]   wdata,
   output logic [NREQ-1:0]         gnt,
   input  logic                    rd_en,
   output logic                    rd_ack,
   output logic                    mem_we,
   output logic [SIZE-1:0]         mem_waddr,
   output logic [WIDTH-1:0]        mem_wdata,
   output logic [SIZE-1:0]         mem_raddr,
   output logic [SIZE:0]           wr_ptr_bin,
   output logic [SIZE:0]           rd_ptr_bin,
   output logic                    fifo_full,
   output logic                    fifo_empty,
   output logic [SIZE:0]           fifo_count
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned PW = SIZE + 1;

   arb_state_e      state_q;
   logic [IW-1:0]   prio_q;
   logic [IW-1:0]   owner_q;
   logic [IW-1:0]   xfer_idx;
   logic [NREQ-1:0] arb_gnt;
   logic [NREQ-1:0] xfer;

   rr_pick #(
      .N (NREQ)
   ) u_rr_pick (
      .req  (req),
      .prio (prio_q),
      .gnt  (arb_gnt)
   );

   // Status comes only from registered pointers, so a write shows up a cycle later.
   assign fifo_count = wr_ptr_bin - rd_ptr_bin;
   assign fifo_empty = (wr_ptr_bin == rd_ptr_bin);
   assign fifo_full  = (fifo_count == PW'(DEPTH));
   assign mem_waddr  = wr_ptr_bin[SIZE-1:0];
   assign mem_raddr  = rd_ptr_bin[SIZE-1:0];
   assign rd_ack     = rd_en & ~fifo_empty;

   // Grant gating on rst keeps the reset cycle free of any write.
   always_comb begin
      gnt = '0;
      if (!rst && !fifo_full) begin
         if (state_q == StArb) begin
            gnt = arb_gnt;
         end else begin
            gnt[owner_q] = req[owner_q];
         end
      end
   end

   assign xfer   = req & gnt;
   assign mem_we = |xfer;

   always_comb begin
      xfer_idx  = '0;
      mem_wdata = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (xfer[i]) begin
            xfer_idx  = IW'(i);
            mem_wdata = wdata[i*WIDTH +: WIDTH];
         end
      end
   end

   // Arbiter FSM: state, lock owner and round-robin priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StArb;
         owner_q <= '0;
         prio_q  <= '0;
      end else begin
         if (mem_we) begin
            prio_q <= IW'(rr_next(32'(xfer_idx), NREQ));
         end
         unique case (state_q)
            StArb: begin
               if (mem_we && lock[xfer_idx]) begin
                  state_q <= StLocked;
                  owner_q <= xfer_idx;
               end
            end
            StLocked: begin
               // Leave after any cycle where the owner drops lock, transfer or not.
               if (!lock[owner_q]) begin
                  state_q <= StArb;
               end
            end
            default: state_q <= StArb;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_bin <= '0;
         rd_ptr_bin <= '0;
      end else begin
         if (mem_we) begin
            wr_ptr_bin <= wr_ptr_bin + PW'(1);
         end
         if (rd_ack) begin
            rd_ptr_bin <= rd_ptr_bin + PW'(1);
         end
      end
   end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb
// Directed bench for fifo_wr_arb with a data scoreboard: words expected to be
// written are queued when stimulus is driven, and checked in order as pops occur.
module tb_fifo_wr_arb;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [3:0]  lock;
   logic [31:0] wdata;
   logic [3:0]  gnt;
   logic        rd_en;
   logic        rd_ack;
   logic        mem_we;
   logic [3:0]  mem_waddr;
   logic [7:0]  mem_wdata;
   logic [3:0]  mem_raddr;
   logic [4:0]  wr_ptr_bin;
   logic [4:0]  rd_ptr_bin;
   logic        fifo_full;
   logic        fifo_empty;
   logic [4:0]  fifo_count;

   int checks   = 0;
   int failures = 0;

   logic [4:0] m_wr;
   logic [4:0] m_rd;
   logic [7:0] data_q[$];
   logic [7:0] tb_mem[16];

   fifo_wr_arb #(
      .SIZE  (4),
      .DEPTH (16),
      .NREQ  (4),
      .WIDTH (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .lock       (lock),
      .wdata      (wdata),
      .gnt        (gnt),
      .rd_en      (rd_en),
      .rd_ack     (rd_ack),
      .mem_we     (mem_we),
      .mem_waddr  (mem_waddr),
      .mem_wdata  (mem_wdata),
      .mem_raddr  (mem_raddr),
      .wr_ptr_bin (wr_ptr_bin),
      .rd_ptr_bin (rd_ptr_bin),
      .fifo_full  (fifo_full),
      .fifo_empty (fifo_empty),
      .fifo_count (fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Storage array stand-in, written from the DUT's write port.
   always @(posedge clk) begin
      if (mem_we) tb_mem[mem_waddr] <= mem_wdata;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h want=%0h", tag, got, exp);
      end
   endtask

   task automatic check_status(input string tag);
      logic [4:0] cnt;
      cnt = m_wr - m_rd;
      check({tag, ".wr_ptr"}, 32'(wr_ptr_bin), 32'(m_wr));
      check({tag, ".rd_ptr"}, 32'(rd_ptr_bin), 32'(m_rd));
      check({tag, ".count"},  32'(fifo_count), 32'(cnt));
      check({tag, ".empty"},  32'(fifo_empty), 32'(cnt == 5'd0));
      check({tag, ".full"},   32'(fifo_full),  32'(cnt == 5'd16));
   endtask

   // One clock cycle: drive, check combinational outputs at negedge, check state after edge.
   task automatic cycle(input logic [3:0] r, input logic [3:0] l, input logic re,
                        input logic [3:0] eg, input logic ea, input string tag);
      logic [7:0] w;
      logic [7:0] exp_rd;
      req   = r;
      lock  = l;
      rd_en = re;
      wdata = $urandom;
      @(negedge clk);
      check({tag, ".gnt"}, 32'(gnt), 32'(eg));
      check({tag, ".we"},  32'(mem_we), 32'(eg != 4'd0));
      if (eg != 4'd0) begin
         w = '0;
         for (int i = 0; i < 4; i++) if (eg[i]) w = wdata[i*8 +: 8];
         check({tag, ".wdata"}, 32'(mem_wdata), 32'(w));
         check({tag, ".waddr"}, 32'(mem_waddr), 32'(m_wr[3:0]));
         data_q.push_back(w);
      end else begin
         check({tag, ".wdata0"}, 32'(mem_wdata), 32'd0);
      end
      check({tag, ".ack"}, 32'(rd_ack), 32'(ea));
      if (ea) begin
         check({tag, ".raddr"}, 32'(mem_raddr), 32'(m_rd[3:0]));
         exp_rd = (data_q.size() > 0) ? data_q.pop_front() : 8'hxx;
         check({tag, ".rdata"}, 32'(tb_mem[mem_raddr]), 32'(exp_rd));
      end
      @(posedge clk);
      #1;
      if (eg != 4'd0) m_wr++;
      if (ea) m_rd++;
      check_status(tag);
   endtask

   initial begin
      rst   = 1'b1;
      req   = '0;
      lock  = '0;
      rd_en = 1'b1;
      wdata = '0;
      m_wr  = '0;
      m_rd  = '0;

      // Reset state
      #3;
      check("rst.gnt", 32'(gnt), 32'd0);
      check("rst.we",  32'(mem_we), 32'd0);
      check("rst.ack", 32'(rd_ack), 32'd0);
      check_status("rst");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Rotation with all requesting, fill to full
      for (int k = 0; k < 16; k++) cycle(4'b1111, 4'b0000, 1'b0, 4'(1 << (k % 4)), 1'b0, "rot");
      cycle(4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b0, "full_gate");

      // Pop while full does not free the same cycle's write
      cycle(4'b0001, 4'b0000, 1'b1, 4'b0000, 1'b1, "full_pop");
      cycle(4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, "after_pop");

      // Drain, then pop on empty is ignored
      for (int k = 0; k < 16; k++) cycle(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, "drain");
      cycle(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, "empty_rd");

      // Fairness: reach prio=2, then partial requests
      cycle(4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b0, "fair_setup");
      cycle(4'b0011, 4'b0000, 1'b0, 4'b0001, 1'b0, "fair_a");
      cycle(4'b0011, 4'b0000, 1'b0, 4'b0010, 1'b0, "fair_b");
      for (int k = 0; k < 3; k++) cycle(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, "fair_drain");

      // Lock burst by requester 2 (prio is 2 here)
      for (int k = 0; k < 3; k++) cycle(4'b1111, 4'b0100, 1'b0, 4'b0100, 1'b0, "lock_hold");
      cycle(4'b1111, 4'b0000, 1'b0, 4'b0100, 1'b0, "lock_drop");
      cycle(4'b1111, 4'b0000, 1'b0, 4'b1000, 1'b0, "lock_next");
      for (int k = 0; k < 5; k++) cycle(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, "lock_drain");

      // Interleaved write/read pairs across the pointer wrap
      for (int k = 0; k < 40; k++) begin
         logic [3:0] oh;
         oh = 4'(1 << $urandom_range(0, 3));
         cycle(oh, 4'b0000, 1'b0, oh, 1'b0, "wrap_wr");
         cycle(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, "wrap_rd");
      end
      cycle(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, "wrap_empty_rd");

      // Async reset in the middle of a locked burst by requester 1
      cycle(4'b0010, 4'b0010, 1'b0, 4'b0010, 1'b0, "lock1");
      req   = 4'b1111;
      lock  = 4'b0010;
      rd_en = 1'b1;
      @(negedge clk);
      check("lock1_hold.gnt", 32'(gnt), 32'b0010);
      check("lock1_hold.ack", 32'(rd_ack), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      m_wr = '0;
      m_rd = '0;
      data_q.delete();
      check("arst.gnt", 32'(gnt), 32'd0);
      check("arst.we",  32'(mem_we), 32'd0);
      check("arst.ack", 32'(rd_ack), 32'd0);
      check_status("arst");
      @(posedge clk);
      #1;
      check_status("arst_edge");
      rst = 1'b0;
      cycle(4'b1111, 4'b0000, 1'b0, 4'b0001, 1'b0, "arst_first");
      cycle(4'b1111, 4'b0000, 1'b0, 4'b0010, 1'b0, "arst_second");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
